multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle RV32I control unit: a registered Moore state machine that latches one instruction, decodes it, and sequences fetch, decode, execute, memory and writeback over several cycles. It adds a memory request/ready handshake, a wait-timeout trap and an illegal-opcode trap, which the single-cycle decoder does not provide. It sits between the instruction fetch port and the datapath: register file, ALU, PC register and data memory.

## Interface
- `ALUOP_W`, default 4: ALU op output width; must be ≥4; codes are zero-extended.
- `RA_W`, default 5: register address width; the low RA_W bits of each instruction field are used.
- `TIMEOUT`, default 15: maximum MEM-state cycles without `mem_ready` before trapping; must be ≥1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `instr` in 32: instruction word; sampled only in FETCH while `instr_valid`=1.
- `instr_valid` in 1: fetch data valid.
- `mem_ready` in 1: data memory completes the access this cycle.
- `state` out 3: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- `ir_we` out 1: instruction-latch pulse.
- `pc_we` out 1: PC update pulse on the last cycle of each instruction.
- `alu_op` out ALUOP_W: ALU operation.
- `rs1`, `rs2`, `rd` out RA_W each: register addresses.
- `reg_we` out 1: register-file write enable.
- `mem_to_reg` out 1: write-back source is memory.
- `alu_src` out 1: ALU operand B is the immediate.
- `branch`, `jump` out 1 each: PC-select qualifiers.
- `mem_req`, `mem_we` out 1 each: data memory request; write when `mem_we`=1.
- `trap` out 1: illegal opcode or memory timeout.

## Operation
- Internal IR register, loaded in FETCH when `instr_valid`=1. `ir_we`=1 in that same cycle, then the FSM goes to DECODE. With `instr_valid`=0 the FSM holds FETCH.
- DECODE registers `rs1`, `rs2`, `rd`, `alu_op`, `alu_src`, `mem_to_reg`, `branch` and `jump` from IR. These hold until the next DECODE.
- Opcodes outside {LUI, AUIPC, LOAD, STORE, OP-IMM, OP, JAL, JALR, BRANCH} take DECODE→TRAP.
- Unused register fields are 0, as follows:
  - LUI, AUIPC, JAL: `rs1`=`rs2`=0.
  - LOAD, OP-IMM, JALR: `rs2`=0.
  - STORE, BRANCH: `rd`=0.
- `alu_op` codes: ADD 0, SUB 1, SLT 2, SLTU 3, SLL 4, SRL 5, SRA 6, AND 7, OR 8, XOR 9.
  - OP-IMM and OP use funct3. `instr[30]` selects SRA for funct3=5 and SUB for OP funct3=0.
  - BRANCH: BEQ/BNE=1, BLT/BGE=2, BLTU/BGEU=3, undefined funct3=0.
  - All other opcodes use 0.
- `alu_src`=1 for LUI, AUIPC, LOAD, STORE and OP-IMM; 0 otherwise. `mem_to_reg`=1 for LOAD only.
- EXEC transitions:
  - LOAD or STORE → MEM.
  - BRANCH → FETCH, with `pc_we`=1 and `branch`=1 in the EXEC cycle.
  - All others → WB.
- MEM:
  - `mem_req`=1 every cycle in MEM; `mem_we`=1 for STORE.
  - On `mem_ready`=1: LOAD → WB; STORE → FETCH with `pc_we`=1 that cycle.
  - A wait counter of width $clog2(TIMEOUT+1) clears on MEM entry and increments each MEM cycle with `mem_ready`=0. If it reaches TIMEOUT → TRAP.
- WB: `reg_we`=1 only if `rd`≠0. `pc_we`=1. `jump`=1 for JAL/JALR. Next state is FETCH.
- TRAP: absorbing state. `trap`=1 and every enable is 0; only reset exits.
- Outputs are decoded from state and registered fields (Moore). Pulse outputs last exactly one cycle.

## Timing
- Reset (asynchronous, `reset_n`=0): state=FETCH, IR=0, counter=0, and every output is 0. Outputs drop without waiting for a clock edge, including mid-MEM (`mem_req` falls immediately).
- First FETCH sample is the first rising edge after `reset_n` rises.
- Cycle counts from the FETCH cycle with `instr_valid`=1, zero wait states:
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - Each memory wait cycle adds 1.
- `mem_ready` is ignored outside MEM. `instr_valid` is ignored outside FETCH. IR does not change outside FETCH.
- `mem_ready`=1 on the same cycle the counter would reach TIMEOUT: completion wins and there is no trap.
- In WB, `rd`=0 gives `reg_we`=0 and `pc_we`=1.

## Test plan
- Reset mid-MEM with a LOAD pending: drive `reset_n`=0 → `mem_req`, `state` and all enables are 0 in the same cycle. Release reset → FETCH.
- ADD x3,x1,x2 (0x002081B3), `instr_valid`=1:
  - Cycle 0: `ir_we`=1.
  - EXEC: `alu_op`=0, `rs1`=1, `rs2`=2.
  - Cycle 3: `reg_we`=1, `rd`=3, `pc_we`=1.
  - Back in FETCH.
- LW x5,0(x1) (0x0000A283), `mem_ready` held low 3 cycles: `mem_req`=1 for 4 cycles, then WB with `mem_to_reg`=1 and `reg_we`=1. Total 8 cycles.
- SW with `mem_ready`=0 for TIMEOUT=15 cycles → `state`=5 and `trap`=1; stays there despite later `mem_ready`.
- BNE (0x00209463): EXEC shows `alu_op`=1, `branch`=1, `pc_we`=1; `reg_we` stays 0; instruction takes 3 cycles.
- Opcode 0x7F → TRAP after DECODE. SRAI (0x4020D193) → `alu_op`=6, `alu_src`=1. ADDI x0 → WB with `reg_we`=0 and `pc_we`=1.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Bundle between the multi-cycle RV32I control unit and its surroundings:
// fetch port, data-memory handshake and datapath control strobes.
interface multicycle_control_if #(
  parameter int ALUOP_W = 4,
  parameter int RA_W    = 5
);
  // Handshake semantics: an instruction transfers on a rising edge where the
  // controller is in FETCH and instr_valid=1 (ir_we marks that cycle); a data
  // access completes on a rising edge where mem_req=1 and mem_ready=1. Neither
  // input has any effect outside its own state.
  logic [31:0]        instr;
  logic               instr_valid;
  logic               mem_ready;

  logic [2:0]         state;
  logic               ir_we;
  logic               pc_we;
  logic [ALUOP_W-1:0] alu_op;
  logic [RA_W-1:0]    rs1;
  logic [RA_W-1:0]    rs2;
  logic [RA_W-1:0]    rd;
  logic               reg_we;
  logic               mem_to_reg;
  logic               alu_src;
  logic               branch;
  logic               jump;
  logic               mem_req;
  logic               mem_we;
  logic               trap;

  modport master (
    input  instr, instr_valid, mem_ready,
    output state, ir_we, pc_we, alu_op, rs1, rs2, rd, reg_we, mem_to_reg,
           alu_src, branch, jump, mem_req, mem_we, trap
  );

  modport slave (
    output instr, instr_valid, mem_ready,
    input  state, ir_we, pc_we, alu_op, rs1, rs2, rd, reg_we, mem_to_reg,
           alu_src, branch, jump, mem_req, mem_we, trap
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory-wait
// timeout trap and an illegal-opcode trap. Outputs decode state plus fields latched in DECODE.
module multicycle_control #(
  parameter int ALUOP_W = 4,
  parameter int RA_W    = 5,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  multicycle_control_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [2:0]         state_q, state_d;
  logic [31:0]        ir_q;
  logic [CNT_W-1:0]   wait_cnt_q;

  logic [ALUOP_W-1:0] alu_op_q;
  logic [RA_W-1:0]    rs1_q, rs2_q, rd_q;
  logic               alu_src_q, mem_to_reg_q;
  logic               is_store_q, is_branch_q, is_jump_q;

  // Decode of the latched instruction; only consumed in DECODE.
  logic [6:0]         opc;
  logic [2:0]         funct3;
  logic               alt;
  logic               legal_d;
  logic [3:0]         code_d;
  logic [RA_W-1:0]    rs1_d, rs2_d, rd_d;
  logic               alu_src_d, mem_to_reg_d;
  logic               is_store_d, is_branch_d, is_jump_d;
  logic               unused_ir;

  assign opc       = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign alt       = ir_q[30];
  assign unused_ir = ^{ir_q[31], ir_q[29:25]};

  // SUB exists only in register-register form; SRA/SRAI both use bit 30.
  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic a,
                                          input logic is_imm);
    logic [3:0] c;
    case (f3)
      3'd0:    c = (a && !is_imm) ? 4'd1 : 4'd0;
      3'd1:    c = 4'd4;
      3'd2:    c = 4'd2;
      3'd3:    c = 4'd3;
      3'd4:    c = 4'd9;
      3'd5:    c = a ? 4'd6 : 4'd5;
      3'd6:    c = 4'd8;
      default: c = 4'd7;
    endcase
    return c;
  endfunction

  always_comb begin
    legal_d      = 1'b1;
    code_d       = 4'd0;
    rs1_d        = ir_q[15 +: RA_W];
    rs2_d        = ir_q[20 +: RA_W];
    rd_d         = ir_q[7 +: RA_W];
    alu_src_d    = 1'b0;
    mem_to_reg_d = 1'b0;
    is_store_d   = 1'b0;
    is_branch_d  = 1'b0;
    is_jump_d    = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        rs1_d     = '0;
        rs2_d     = '0;
        alu_src_d = 1'b1;
      end
      OPC_JAL: begin
        rs1_d     = '0;
        rs2_d     = '0;
        is_jump_d = 1'b1;
      end
      OPC_JALR: begin
        rs2_d     = '0;
        is_jump_d = 1'b1;
      end
      OPC_LOAD: begin
        rs2_d        = '0;
        alu_src_d    = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      OPC_STORE: begin
        rd_d       = '0;
        alu_src_d  = 1'b1;
        is_store_d = 1'b1;
      end
      OPC_OP_IMM: begin
        rs2_d     = '0;
        alu_src_d = 1'b1;
        code_d    = alu_code(funct3, alt, 1'b1);
      end
      OPC_OP: begin
        code_d = alu_code(funct3, alt, 1'b0);
      end
      OPC_BRANCH: begin
        rd_d        = '0;
        is_branch_d = 1'b1;
        case (funct3)
          3'd0, 3'd1: code_d = 4'd1;
          3'd4, 3'd5: code_d = 4'd2;
          3'd6, 3'd7: code_d = 4'd3;
          default:    code_d = 4'd0;
        endcase
      end
      default: begin
        legal_d = 1'b0;
        rs1_d   = '0;
        rs2_d   = '0;
        rd_d    = '0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.instr_valid) state_d = S_DECODE;
      S_DECODE: state_d = legal_d ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (mem_to_reg_q || is_store_q) state_d = S_MEM;
        else if (is_branch_q)          state_d = S_FETCH;
        else                           state_d = S_WB;
      end
      S_MEM: begin
        // Completion takes priority over the timeout on the final allowed cycle.
        if (bus.mem_ready)                             state_d = is_store_q ? S_FETCH : S_WB;
        else if (wait_cnt_q == CNT_W'(TIMEOUT - 1))    state_d = S_TRAP;
      end
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_FETCH;
      ir_q         <= '0;
      wait_cnt_q   <= '0;
      alu_op_q     <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      alu_src_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      is_store_q   <= 1'b0;
      is_branch_q  <= 1'b0;
      is_jump_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && bus.instr_valid) ir_q <= bus.instr;
      if (state_q == S_EXEC)                          wait_cnt_q <= '0;
      else if (state_q == S_MEM && !bus.mem_ready)    wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      if (state_q == S_DECODE) begin
        alu_op_q     <= ALUOP_W'(code_d);
        rs1_q        <= rs1_d;
        rs2_q        <= rs2_d;
        rd_q         <= rd_d;
        alu_src_q    <= alu_src_d;
        mem_to_reg_q <= mem_to_reg_d;
        is_store_q   <= is_store_d;
        is_branch_q  <= is_branch_d;
        is_jump_q    <= is_jump_d;
      end
    end
  end

  // ir_we is qualified by reset_n so that it is low while reset is held.
  assign bus.state      = state_q;
  assign bus.ir_we      = reset_n && (state_q == S_FETCH) && bus.instr_valid;
  assign bus.pc_we      = ((state_q == S_EXEC) && is_branch_q)
                        | ((state_q == S_MEM) && is_store_q && bus.mem_ready)
                        | (state_q == S_WB);
  assign bus.alu_op     = alu_op_q;
  assign bus.rs1        = rs1_q;
  assign bus.rs2        = rs2_q;
  assign bus.rd         = rd_q;
  assign bus.reg_we     = (state_q == S_WB) && (rd_q != '0);
  assign bus.mem_to_reg = mem_to_reg_q;
  assign bus.alu_src    = alu_src_q;
  assign bus.branch     = (state_q == S_EXEC) && is_branch_q;
  assign bus.jump       = (state_q == S_WB) && is_jump_q;
  assign bus.mem_req    = (state_q == S_MEM);
  assign bus.mem_we     = (state_q == S_MEM) && is_store_q;
  assign bus.trap       = (state_q == S_TRAP);

endmodule
